adc_mon_seq: RTL and testbench

Measurement sequencer that shares the single 8-bit charger ADC between the battery voltage, current and temperature channels. It sits between the monitor-enable outputs of the charger controller and the ADC front-end mux. It round-robins over the enabled channels, handles mux settling and conversion handshake, and registers the per-channel results. It drives the `vbat`, `ibat`, `tbat` and `vtok` inputs of the charger controller.

---
 rtl/adc_mon_pkg.sv | 39 +++
 rtl/adc_seq_timer.sv | 27 ++
 rtl/adc_mon_seq.sv | 181 ++++++++++++++++++
 tb/tb_adc_mon_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_mon_pkg.sv
// rtl/adc_mon_pkg.sv - shared encodings and helpers for the ADC measurement sequencer
package adc_mon_pkg;

    localparam int ADC_W = 8;

    localparam logic [1:0] CH_V = 2'd0;
    localparam logic [1:0] CH_I = 2'd1;
    localparam logic [1:0] CH_T = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEL  = 2'd1,
        S_CONV = 2'd2
    } seq_state_t;

    // Next channel in the fixed V -> I -> T -> V rotation.
    function automatic logic [1:0] ch_after(input logic [1:0] ch);
        logic [1:0] nxt;
        case (ch)
            CH_V:    nxt = CH_I;
            CH_I:    nxt = CH_T;
            default: nxt = CH_V;
        endcase
        return nxt;
    endfunction

    // Enable bit of a channel; ch_en is {tmonen, imonen, vmonen}.
    function automatic logic ch_enabled(input logic [1:0] ch, input logic [2:0] ch_en);
        logic hit;
        case (ch)
            CH_V:    hit = ch_en[0];
            CH_I:    hit = ch_en[1];
            CH_T:    hit = ch_en[2];
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// rtl/adc_seq_timer.sv - loadable down-counter shared by mux settling and conversion timeout
module adc_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/adc_mon_seq.sv
// rtl/adc_mon_seq.sv - round-robin sequencer sharing the charger ADC across V, I and T
module adc_mon_seq
    import adc_mon_pkg::*;
#(
    parameter int SETTLE_CYC   = 4,
    parameter int CONV_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             vmonen,
    input  logic             imonen,
    input  logic             tmonen,
    output logic [1:0]       adc_sel,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] vbat,
    output logic [ADC_W-1:0] ibat,
    output logic [ADC_W-1:0] tbat,
    output logic             vtok,
    output logic             adc_err,
    inout  wire              dvdd,
    inout  wire              dgnd
);

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] CONV_LD   = 8'(CONV_TIMEOUT - 1);

    seq_state_t state;
    seq_state_t next_state;

    logic [1:0] ptr;
    logic       rr_armed;
    logic [2:0] ch_en;
    logic [1:0] scan0;
    logic [1:0] scan1;
    logic [1:0] scan2;
    logic [1:0] pick_ch;
    logic       pick_ok;
    logic       conv_ok;
    logic       conv_to;
    logic       timer_load;
    logic [7:0] timer_val;
    logic       timer_zero;
    logic [2:0] ch_valid;

    // Supply pins are only carried through the hierarchy; fold them into a named sink.
    logic unused_supply;
    assign unused_supply = &{1'b0, dvdd, dgnd};

    assign ch_en   = {tmonen, imonen, vmonen};
    assign adc_sel = ptr;

    // Round-robin pick: after reset scan V,I,T; afterwards scan ptr+1, ptr+2, then ptr itself.
    always_comb begin
        scan0   = rr_armed ? ch_after(ptr) : CH_V;
        scan1   = ch_after(scan0);
        scan2   = ch_after(scan1);
        pick_ch = scan0;
        pick_ok = 1'b1;
        if (ch_enabled(scan0, ch_en)) begin
            pick_ch = scan0;
        end else if (ch_enabled(scan1, ch_en)) begin
            pick_ch = scan1;
        end else if (ch_enabled(scan2, ch_en)) begin
            pick_ch = scan2;
        end else begin
            pick_ok = 1'b0;
        end
    end

    // Next-state logic; a low enable aborts from any state, done beats timeout.
    always_comb begin
        next_state = state;
        conv_ok    = 1'b0;
        conv_to    = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && pick_ok) begin
                    next_state = S_SEL;
                end
            end
            S_SEL: begin
                if (!en) begin
                    next_state = S_IDLE;
                end else if (timer_zero) begin
                    next_state = S_CONV;
                end
            end
            S_CONV: begin
                if (!en) begin
                    next_state = S_IDLE;
                end else if (adc_done) begin
                    conv_ok    = 1'b1;
                    next_state = pick_ok ? S_SEL : S_IDLE;
                end else if (timer_zero) begin
                    conv_to    = 1'b1;
                    next_state = pick_ok ? S_SEL : S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Every state entry reloads the shared timer with that state's budget.
    assign timer_load = (next_state != state);
    assign timer_val  = (next_state == S_SEL) ? SETTLE_LD : CONV_LD;

    adc_seq_timer #(
        .W(8)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch the picked channel on SEL entry and pulse start on CONV entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= CH_V;
            rr_armed  <= 1'b0;
            adc_start <= 1'b0;
        end else begin
            adc_start <= (next_state == S_CONV) && (state != S_CONV);
            if ((next_state == S_SEL) && (state != S_SEL)) begin
                ptr      <= pick_ch;
                rr_armed <= 1'b1;
            end
        end
    end

    // Capture the converted sample into the register of the channel being measured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vbat <= '0;
            ibat <= '0;
            tbat <= '0;
        end else if (conv_ok) begin
            case (ptr)
                CH_V:    vbat <= adc_data;
                CH_I:    ibat <= adc_data;
                default: tbat <= adc_data;
            endcase
        end
    end

    // Per-channel validity, sticky timeout flag and the registered voltage/temperature ok.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_valid <= '0;
            adc_err  <= 1'b0;
            vtok     <= 1'b0;
        end else begin
            vtok <= en & ch_valid[CH_V] & ch_valid[CH_T] & ~adc_err;
            if (!en) begin
                ch_valid <= '0;
                adc_err  <= 1'b0;
            end else if (conv_ok) begin
                ch_valid[ptr] <= 1'b1;
            end else if (conv_to) begin
                ch_valid[ptr] <= 1'b0;
                adc_err       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_mon_seq.sv
// tb/tb_adc_mon_seq.sv - randomized self-checking bench for adc_mon_seq
`timescale 1ns/1ps
module tb_adc_mon_seq;

    localparam int SETTLE_CYC   = 4;
    localparam int CONV_TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       vmonen;
    logic       imonen;
    logic       tmonen;
    logic       adc_done;
    logic [7:0] adc_data;
    logic [1:0] adc_sel;
    logic       adc_start;
    logic [7:0] vbat;
    logic [7:0] ibat;
    logic [7:0] tbat;
    logic       vtok;
    logic       adc_err;
    wire        dvdd = 1'b1;
    wire        dgnd = 1'b0;

    adc_mon_seq #(
        .SETTLE_CYC   (SETTLE_CYC),
        .CONV_TIMEOUT (CONV_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .vmonen    (vmonen),
        .imonen    (imonen),
        .tmonen    (tmonen),
        .adc_sel   (adc_sel),
        .adc_start (adc_start),
        .adc_done  (adc_done),
        .adc_data  (adc_data),
        .vbat      (vbat),
        .ibat      (ibat),
        .tbat      (tbat),
        .vtok      (vtok),
        .adc_err   (adc_err),
        .dvdd      (dvdd),
        .dgnd      (dgnd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_ref  = 0;
    int exp_gap = 0;

    logic [7:0] m_reg [3];
    bit         m_valid [3];
    bit         m_err;
    int         m_last;
    bit         m_armed;

    function automatic int model_pick();
        bit ens [3];
        ens[0] = vmonen;
        ens[1] = imonen;
        ens[2] = tmonen;
        if (!m_armed) begin
            for (int c = 0; c < 3; c++) if (ens[c]) return c;
        end else begin
            for (int k = 1; k <= 3; k++) if (ens[(m_last + k) % 3]) return (m_last + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [7:0] dut_reg(input int c);
        if (c == 0) return vbat;
        if (c == 1) return ibat;
        return tbat;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_reg[c]   = 8'h00;
            m_valid[c] = 1'b0;
        end
        m_err   = 1'b0;
        m_last  = 0;
        m_armed = 1'b0;
    endtask

    task automatic model_disable();
        for (int c = 0; c < 3; c++) m_valid[c] = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_start(input bit junk);
        int n;
        n = 0;
        while (adc_start !== 1'b1 && n < 400) begin
            if (junk) begin
                adc_done = 1'($urandom);
                adc_data = 8'($urandom);
            end
            tick();
            n++;
        end
        adc_done = 1'b0;
        if (adc_start !== 1'b1) begin
            checks++; errors++;
            $display("FAIL start_wait no adc_start within %0d cycles", n);
        end
        if (junk) begin
            checks++;
            if ({vbat, ibat, tbat} !== {m_reg[0], m_reg[1], m_reg[2]}) begin
                errors++;
                $display("FAIL done_ignored regs %h %h %h expected %h %h %h",
                         vbat, ibat, tbat, m_reg[0], m_reg[1], m_reg[2]);
            end
        end
    endtask

    task automatic do_conv(input int lat, input logic [7:0] d, input bit to,
                           input logic [2:0] nxt_en, input bit junk);
        int   ch;
        logic exp_vtok;
        wait_start(junk);
        checks++;
        if (cyc - t_ref != exp_gap) begin
            errors++;
            $display("FAIL start_gap got %0d cycles expected %0d", cyc - t_ref, exp_gap);
        end
        ch = model_pick();
        checks++;
        if (ch < 0 || adc_sel !== 2'(ch)) begin
            errors++;
            $display("FAIL adc_sel got %0d expected %0d", adc_sel, ch);
        end
        if (ch < 0) ch = 0;
        m_last  = ch;
        m_armed = 1'b1;
        if (to) begin
            for (int i = 0; i < CONV_TIMEOUT; i++) begin
                if (i == CONV_TIMEOUT - 1) {tmonen, imonen, vmonen} = nxt_en;
                tick();
                if (i == 0) begin
                    checks++;
                    if (adc_start !== 1'b0) begin
                        errors++;
                        $display("FAIL start_pulse got %b expected 0", adc_start);
                    end
                end
                if (i == CONV_TIMEOUT - 2) begin
                    checks++;
                    if (adc_err !== m_err) begin
                        errors++;
                        $display("FAIL early_timeout adc_err got %b expected %b", adc_err, m_err);
                    end
                end
            end
            m_err       = 1'b1;
            m_valid[ch] = 1'b0;
        end else begin
            for (int i = 0; i <= lat; i++) begin
                if (i == lat) begin
                    adc_done = 1'b1;
                    adc_data = d;
                    {tmonen, imonen, vmonen} = nxt_en;
                end
                tick();
                if (i == 0) begin
                    checks++;
                    if (adc_start !== 1'b0) begin
                        errors++;
                        $display("FAIL start_pulse got %b expected 0", adc_start);
                    end
                end
            end
            adc_done    = 1'b0;
            adc_data    = 8'($urandom);
            m_reg[ch]   = d;
            m_valid[ch] = 1'b1;
        end
        checks++;
        if (dut_reg(ch) !== m_reg[ch]) begin
            errors++;
            $display("FAIL data_ch%0d got %h expected %h", ch, dut_reg(ch), m_reg[ch]);
        end
        checks++;
        if (adc_err !== m_err) begin
            errors++;
            $display("FAIL adc_err got %b expected %b", adc_err, m_err);
        end
        t_ref   = cyc;
        exp_gap = SETTLE_CYC;
        tick();
        exp_vtok = en & m_valid[0] & m_valid[2] & ~m_err;
        checks++;
        if (vtok !== exp_vtok) begin
            errors++;
            $display("FAIL vtok got %b expected %b", vtok, exp_vtok);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        {tmonen, imonen, vmonen} = 3'b000;
        adc_done = 1'b0; adc_data = 8'h00;
        repeat (3) tick();
        checks++;
        if ({adc_sel, adc_start} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl sel %0d start %b expected 0 0", adc_sel, adc_start);
        end
        checks++;
        if ({vbat, ibat, tbat} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h expected 00 00 00", vbat, ibat, tbat);
        end
        checks++;
        if ({vtok, adc_err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags vtok %b err %b expected 0 0", vtok, adc_err);
        end
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_voltage_only();
        {tmonen, imonen, vmonen} = 3'b001;
        en      = 1'b1;
        t_ref   = cyc;
        exp_gap = 1 + SETTLE_CYC;
        do_conv(3, 8'hC0, 1'b0, 3'b001, 1'b0);
        do_conv($urandom_range(0, 6), 8'($urandom), 1'b0, 3'b001, 1'b0);
        en = 1'b0;
        tick();
        model_disable();
        repeat (2) tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] tbl [3];
        tbl[0] = 8'hA0; tbl[1] = 8'h30; tbl[2] = 8'h55;
        pulse_reset();
        {tmonen, imonen, vmonen} = 3'b111;
        en      = 1'b1;
        t_ref   = cyc;
        exp_gap = 1 + SETTLE_CYC;
        for (int n = 0; n < 6; n++) begin
            do_conv($urandom_range(0, 8), tbl[n % 3], 1'b0, 3'b111, 1'b0);
        end
    endtask

    task automatic test_timeout();
        do_conv($urandom_range(0, 5), 8'($urandom), 1'b0, 3'b111, 1'b0);
        do_conv(0, 8'h00, 1'b1, 3'b111, 1'b0);
        do_conv($urandom_range(0, 5), 8'($urandom), 1'b0, 3'b111, 1'b0);
    endtask

    task automatic test_en_drop();
        int starts;
        wait_start(1'b0);
        m_last  = model_pick();
        m_armed = 1'b1;
        repeat (2) tick();
        en = 1'b0;
        tick();
        model_disable();
        checks++;
        if (adc_start !== 1'b0 || adc_err !== 1'b0 || vtok !== 1'b0) begin
            errors++;
            $display("FAIL en_drop start %b err %b vtok %b expected 0 0 0", adc_start, adc_err, vtok);
        end
        checks++;
        if (vbat !== m_reg[0]) begin
            errors++;
            $display("FAIL en_drop_vbat got %h expected %h", vbat, m_reg[0]);
        end
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            adc_done = 1'($urandom);
            adc_data = 8'($urandom);
            tick();
            if (adc_start === 1'b1) starts++;
        end
        adc_done = 1'b0;
        checks++;
        if (starts != 0 || {vbat, ibat, tbat} !== {m_reg[0], m_reg[1], m_reg[2]}) begin
            errors++;
            $display("FAIL idle_hold starts %0d regs %h %h %h expected 0 %h %h %h",
                     starts, vbat, ibat, tbat, m_reg[0], m_reg[1], m_reg[2]);
        end
    endtask

    task automatic test_done_at_timeout();
        en      = 1'b1;
        t_ref   = cyc;
        exp_gap = 1 + SETTLE_CYC;
        do_conv(CONV_TIMEOUT - 1, 8'($urandom), 1'b0, 3'b111, 1'b0);
    endtask

    task automatic test_random();
        int starts;
        for (int n = 0; n < 24; n++) begin
            do_conv($urandom_range(0, 12), 8'($urandom), ($urandom_range(0, 5) == 0),
                    3'($urandom_range(1, 7)), 1'($urandom));
        end
        do_conv($urandom_range(0, 4), 8'($urandom), 1'b0, 3'b000, 1'b0);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (adc_start === 1'b1) starts++;
        end
        checks++;
        if (starts != 0 || adc_sel !== 2'(m_last)) begin
            errors++;
            $display("FAIL all_disabled starts %0d sel %0d expected 0 %0d", starts, adc_sel, m_last);
        end
        {tmonen, imonen, vmonen} = 3'b010;
        t_ref   = cyc;
        exp_gap = 1 + SETTLE_CYC;
        do_conv($urandom_range(0, 6), 8'($urandom), 1'b0, 3'b111, 1'b0);
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        while (model_pick() == 0 && guard < 3) begin
            do_conv($urandom_range(0, 4), 8'($urandom) | 8'h01, 1'b0, 3'b111, 1'b0);
            guard++;
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({adc_sel, adc_start, vtok, adc_err} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset_ctrl sel %0d start %b vtok %b err %b expected 0",
                     adc_sel, adc_start, vtok, adc_err);
        end
        checks++;
        if ({vbat, ibat, tbat} !== 24'h0) begin
            errors++;
            $display("FAIL async_reset_data got %h %h %h expected 00 00 00", vbat, ibat, tbat);
        end
        tick();
        rst = 1'b0;
        model_reset();
        t_ref   = cyc;
        exp_gap = 1 + SETTLE_CYC;
        do_conv($urandom_range(0, 4), 8'($urandom), 1'b0, 3'b111, 1'b0);
    endtask

    initial begin
        test_reset();
        test_voltage_only();
        test_round_robin();
        test_timeout();
        test_en_drop();
        test_done_at_timeout();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
